test_monitor: RTL and testbench
===============================

TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 Parameter TOHOST_ADDR, default 32'h0000_1000: word address of the pass/fail mailbox.
REQ-002 Parameter CONSOLE_ADDR, default 32'h0000_1004: word address of the character output port.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000: cycle budget before the monitor declares a timeout.
REQ-004 Parameter CON_DEPTH, default 8: console FIFO depth, power of two, minimum 2.
REQ-005 clk  in  1: single clock; all state updates on rising edge.
REQ-006 rst  in  1: asynchronous, active-high reset.
REQ-007 mem_we  in  1: CPU data-memory write strobe from the MEM stage.
REQ-008 mem_addr  in  32: CPU data-memory byte address.
REQ-009 mem_wdata  in  32: CPU store data.
REQ-010 retire_valid  in  1: one instruction retired at WB this cycle.
REQ-011 done  out  1: test reached a terminal state (PASS, FAIL or TIMEOUT).
REQ-012 pass  out  1: terminal state is PASS.
REQ-013 fail_code  out  31: failure code; zero unless the state is FAIL.
REQ-014 timeout  out  1: terminal state is TIMEOUT.
REQ-015 cycle_count  out  32: cycles spent in RUN.
REQ-016 instret_count  out  32: instructions retired while in RUN.
REQ-017 con_valid  out  1: console character available.
REQ-018 con_data  out  8: console character at FIFO head.
REQ-019 con_ready  in  1: consumer accepts the character when con_valid && con_ready.
REQ-020 con_overflow  out  1: sticky; a console push was dropped.

Function
REQ-021 The FSM SHALL have states RUN, PASS, FAIL and TIMEOUT; RUN is the only non-terminal state, and every terminal state is held until reset.
REQ-022 In RUN, a write (mem_we=1) to TOHOST_ADDR with wdata[0]=1 SHALL transition to PASS when wdata[31:1]=0, otherwise to FAIL with fail_code latched as wdata[31:1], effective next cycle.
REQ-023 A TOHOST_ADDR write with wdata[0]=0 SHALL be ignored.
REQ-024 In RUN, when cycle_count equals TIMEOUT_CYCLES-1 and no qualifying tohost write occurs that cycle, the FSM SHALL enter TIMEOUT next cycle.
REQ-025 When a qualifying tohost write and the timeout condition occur in the same cycle, the tohost write SHALL win.
REQ-026 Writes to TOHOST_ADDR in a terminal state SHALL be ignored.
REQ-027 cycle_count SHALL increment once per cycle in RUN and saturate at 32'hFFFF_FFFF.
REQ-028 instret_count SHALL increment on retire_valid in RUN and saturate at 32'hFFFF_FFFF.
REQ-029 Both counters SHALL freeze on entering a terminal state.
REQ-030 done, pass and timeout SHALL be decoded directly from the registered state, giving one cycle of latency from the triggering write.
REQ-031 A write to CONSOLE_ADDR SHALL push mem_wdata[7:0] into the console FIFO; con_data SHALL present the head entry, and con_valid SHALL equal not-empty.
REQ-032 A push into a full FIFO SHALL be dropped and set con_overflow, except when a pop occurs in the same cycle, in which case both the pop and the push SHALL succeed.
REQ-033 The console path SHALL remain active in terminal states so that buffered characters can drain.
REQ-034 Writes to any address other than TOHOST_ADDR and CONSOLE_ADDR SHALL be ignored.

Reset
REQ-035 On rst assertion, the block SHALL asynchronously set the state to RUN and clear both counters, fail_code, the FIFO pointers and con_overflow.
REQ-036 The outputs SHALL read done=0, pass=0, timeout=0 and con_valid=0 while in reset.
REQ-037 A reset asserted mid-test or from a terminal state SHALL restart the test cleanly and discard buffered characters.

Configuration
REQ-038 Macro TEST_MONITOR_CONSOLE_EN SHALL enable the console FIFO as described in REQ-031 to REQ-033.
REQ-039 Without TEST_MONITOR_CONSOLE_EN, all console ports SHALL remain present; con_valid, con_data and con_overflow SHALL be tied to 0, CONSOLE_ADDR writes SHALL be ignored, and no FIFO storage SHALL be instantiated.

Structure
REQ-040 Package test_monitor_pkg SHALL hold the state enum, the default TOHOST/CONSOLE addresses and the tohost encoding constants (pass value 1, fail bit 0).
REQ-041 The console buffer SHALL be a sub-module sync_fifo, parameterised by width and depth, providing full/empty flags.

Verification
REQ-042 Reset, then write 32'h1 to 0x1000 at cycle 50 -> done=1 and pass=1 at cycle 51, with cycle_count frozen at 51 and fail_code=0.
REQ-043 Write 32'h7 to 0x1000 -> state FAIL, fail_code=3, pass=0, done=1; a subsequent write of 32'h1 leaves the state at FAIL.
REQ-044 TIMEOUT_CYCLES=20 with no writes -> timeout=1 after 20 cycles and cycle_count=20; with a 32'h1 write on the cycle when count=19, the result is PASS rather than TIMEOUT.
REQ-045 With console enabled and con_ready=0, push 9 characters 'A'..'I' -> con_overflow=1, 8 entries retained; raising con_ready drains 'A'..'H' in order, after which con_valid=0.
REQ-046 With console enabled, push into a full FIFO in the same cycle as a pop -> no overflow, and the FIFO stays full with the new character at the tail.
REQ-047 Assert rst mid-RUN after 10 retires -> instret_count=0, done=0 and the FIFO is empty; the test then completes normally.

Source files
------------

// File: rtl/test_monitor_pkg.sv
// test_monitor_pkg: shared types and constants for the test_monitor slice.
//   tm_state_e           - monitor FSM states (RUN is the only non-terminal one)
//   DEFAULT_*_ADDR       - default mailbox / console addresses
//   TOHOST_PASS_VAL      - tohost word that signals PASS
//   TOHOST_DONE_BIT      - tohost bit that marks a write as a test result
//   sat_inc()            - 32-bit saturating increment used by both counters
package test_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } tm_state_e;

    localparam logic [31:0] DEFAULT_TOHOST_ADDR  = 32'h0000_1000;
    localparam logic [31:0] DEFAULT_CONSOLE_ADDR = 32'h0000_1004;

    localparam logic [31:0] TOHOST_PASS_VAL = 32'h0000_0001;
    localparam int unsigned TOHOST_DONE_BIT = 0;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags.
//   clk, rst     - clock, asynchronous active-high reset (clears pointers only)
//   push_i       - write push_data_i; accepted when not full, or when full and
//                  a pop happens in the same cycle
//   pop_i        - remove head entry; ignored when empty
//   pop_data_o   - head entry (valid when !empty_o)
//   full_o       - DEPTH entries held
//   empty_o      - no entries held
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // When full, the slot being written is the head being popped this cycle,
    // so a simultaneous push/pop is safe.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/test_monitor.sv
// test_monitor: watches CPU stores for a tohost pass/fail result, enforces a
// cycle budget, counts cycles/retired instructions, and optionally buffers
// console characters.
//   clk, rst                      - clock, asynchronous active-high reset
//   mem_we, mem_addr, mem_wdata   - MEM-stage store
//   retire_valid                  - one instruction retired this cycle
//   done, pass, timeout           - terminal-state decode of the FSM
//   fail_code                     - tohost[31:1] of a failing result
//   cycle_count, instret_count    - saturating counters, live only in RUN
//   con_valid, con_data, con_ready- console character stream (valid/ready)
//   con_overflow                  - sticky: a console character was dropped
// Macro TEST_MONITOR_CONSOLE_EN enables the console FIFO; without it the
// console outputs are tied to zero and CONSOLE_ADDR writes are ignored.
module test_monitor
    import test_monitor_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR    = DEFAULT_TOHOST_ADDR,
    parameter logic [31:0] CONSOLE_ADDR   = DEFAULT_CONSOLE_ADDR,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CON_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        retire_valid,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code,
    output logic        timeout,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        con_overflow
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    tm_state_e   state_q, state_d;
    logic [30:0] fail_code_q, fail_code_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instret_q, instret_d;
    logic        tohost_hit;

    assign tohost_hit = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[TOHOST_DONE_BIT];

    always_comb begin
        state_d     = state_q;
        fail_code_d = fail_code_q;
        cycle_d     = cycle_q;
        instret_d   = instret_q;
        if (state_q == ST_RUN) begin
            cycle_d = sat_inc(cycle_q);
            if (retire_valid) begin
                instret_d = sat_inc(instret_q);
            end
            // A tohost result takes priority over an expiring budget.
            if (tohost_hit) begin
                if (mem_wdata == TOHOST_PASS_VAL) begin
                    state_d = ST_PASS;
                end else begin
                    state_d     = ST_FAIL;
                    fail_code_d = mem_wdata[31:1];
                end
            end else if (cycle_q == TIMEOUT_LAST) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            fail_code_q <= '0;
            cycle_q     <= '0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            fail_code_q <= fail_code_d;
            cycle_q     <= cycle_d;
            instret_q   <= instret_d;
        end
    end

    assign done          = (state_q != ST_RUN);
    assign pass          = (state_q == ST_PASS);
    assign timeout       = (state_q == ST_TIMEOUT);
    assign fail_code     = fail_code_q;
    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;

`ifdef TEST_MONITOR_CONSOLE_EN
    logic con_push, con_pop, con_full, con_empty, con_overflow_q;

    // Console stays live in every FSM state so buffered text can drain.
    assign con_push = mem_we && (mem_addr == CONSOLE_ADDR);
    assign con_pop  = con_ready && !con_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (CON_DEPTH)
    ) u_con_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (con_push),
        .push_data_i (mem_wdata[7:0]),
        .pop_i       (con_pop),
        .pop_data_o  (con_data),
        .full_o      (con_full),
        .empty_o     (con_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            con_overflow_q <= 1'b0;
        end else if (con_push && con_full && !con_pop) begin
            con_overflow_q <= 1'b1;
        end
    end

    assign con_valid    = !con_empty;
    assign con_overflow = con_overflow_q;
`else
    logic unused_console;
    assign unused_console = ^{con_ready, CONSOLE_ADDR, 32'(CON_DEPTH)};

    assign con_valid    = 1'b0;
    assign con_data     = '0;
    assign con_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_test_monitor.sv
module tb_test_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        retire_valid = 1'b0;
    logic        con_ready = 1'b0;

    logic        done, pass, timeout, con_valid, con_overflow;
    logic [30:0] fail_code;
    logic [31:0] cycle_count, instret_count;
    logic [7:0]  con_data;

    logic        t_done, t_pass, t_timeout, t_con_valid, t_con_overflow;
    logic [30:0] t_fail_code;
    logic [31:0] t_cycle_count, t_instret_count;
    logic [7:0]  t_con_data;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    test_monitor dut (
        .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .retire_valid(retire_valid),
        .done(done), .pass(pass), .fail_code(fail_code), .timeout(timeout),
        .cycle_count(cycle_count), .instret_count(instret_count),
        .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
        .con_overflow(con_overflow)
    );

    test_monitor #(.TIMEOUT_CYCLES(20)) dut_to (
        .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .retire_valid(retire_valid),
        .done(t_done), .pass(t_pass), .fail_code(t_fail_code), .timeout(t_timeout),
        .cycle_count(t_cycle_count), .instret_count(t_instret_count),
        .con_valid(t_con_valid), .con_data(t_con_data), .con_ready(con_ready),
        .con_overflow(t_con_overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mem_we       = 1'b0;
        retire_valid = 1'b0;
        con_ready    = 1'b0;
        rst          = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        mem_we    = 1'b1;
        mem_addr  = addr;
        mem_wdata = data;
        tick();
        mem_we    = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        con_ready = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (!con_valid) break;
            if (exp_q.size() == 0) begin
                check_eq("con_extra", 32'(con_valid), 32'd0);
            end else begin
                check_eq("con_data", 32'(con_data), 32'(exp_q.pop_front()));
            end
            tick();
        end
        con_ready = 1'b0;
        check_eq("con_left", 32'(exp_q.size()), 32'd0);
        check_eq("con_valid_empty", 32'(con_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state, sampled while rst is held.
        #1;
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_pass", 32'(pass), 32'd0);
        check_eq("rst_timeout", 32'(timeout), 32'd0);
        check_eq("rst_con_valid", 32'(con_valid), 32'd0);
        check_eq("rst_cycle", cycle_count, 32'd0);

        // PASS at cycle 50.
        do_reset();
        repeat (50) tick();
        check_eq("p_cycle50", cycle_count, 32'd50);
        check_eq("p_done_pre", 32'(done), 32'd0);
        wr(32'h1000, 32'h1);
        check_eq("p_done", 32'(done), 32'd1);
        check_eq("p_pass", 32'(pass), 32'd1);
        check_eq("p_timeout", 32'(timeout), 32'd0);
        check_eq("p_fail_code", 32'(fail_code), 32'd0);
        check_eq("p_cycle51", cycle_count, 32'd51);
        repeat (5) tick();
        check_eq("p_cycle_frozen", cycle_count, 32'd51);
        check_eq("p_pass_held", 32'(pass), 32'd1);

        // Ignored writes, retire counting, FAIL and terminal hold.
        do_reset();
        retire_valid = 1'b1;
        repeat (7) tick();
        retire_valid = 1'b0;
        wr(32'h1000, 32'h6);
        wr(32'h1008, 32'h1);
        tick();
        check_eq("ign_done", 32'(done), 32'd0);
        check_eq("f_instret7", instret_count, 32'd7);
        check_eq("f_cycle10", cycle_count, 32'd10);
        retire_valid = 1'b1;
        wr(32'h1000, 32'h7);
        check_eq("f_done", 32'(done), 32'd1);
        check_eq("f_pass", 32'(pass), 32'd0);
        check_eq("f_code", 32'(fail_code), 32'd3);
        check_eq("f_instret8", instret_count, 32'd8);
        wr(32'h1000, 32'h1);
        tick();
        retire_valid = 1'b0;
        check_eq("f_hold_pass", 32'(pass), 32'd0);
        check_eq("f_hold_code", 32'(fail_code), 32'd3);
        check_eq("f_instret_frozen", instret_count, 32'd8);
        check_eq("f_cycle_frozen", cycle_count, 32'd11);

        // Asynchronous reset from a terminal state, no clock edge needed.
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check_eq("ar_done", 32'(done), 32'd0);
        check_eq("ar_code", 32'(fail_code), 32'd0);
        check_eq("ar_cycle", cycle_count, 32'd0);

        // Maximum fail code.
        do_reset();
        wr(32'h1000, 32'hFFFF_FFFF);
        check_eq("fmax_code", 32'(fail_code), 32'h7FFF_FFFF);

        // Timeout with a 20-cycle budget.
        do_reset();
        repeat (19) tick();
        check_eq("to_cycle19", t_cycle_count, 32'd19);
        check_eq("to_done_pre", 32'(t_done), 32'd0);
        tick();
        check_eq("to_timeout", 32'(t_timeout), 32'd1);
        check_eq("to_done", 32'(t_done), 32'd1);
        check_eq("to_pass", 32'(t_pass), 32'd0);
        check_eq("to_cycle20", t_cycle_count, 32'd20);

        // PASS beats timeout in the same cycle.
        do_reset();
        repeat (19) tick();
        wr(32'h1000, 32'h1);
        tick();
        check_eq("race_pass", 32'(t_pass), 32'd1);
        check_eq("race_timeout", 32'(t_timeout), 32'd0);

        // Mid-RUN reset after 10 retires, then normal completion.
        do_reset();
        retire_valid = 1'b1;
        repeat (4) tick();
        wr(32'h1004, 32'h51);
        wr(32'h1004, 32'h52);
        repeat (4) tick();
        retire_valid = 1'b0;
        check_eq("mr_instret10", instret_count, 32'd10);
        rst = 1'b1;
        #1;
        check_eq("mr_instret0", instret_count, 32'd0);
        check_eq("mr_done", 32'(done), 32'd0);
        check_eq("mr_con_valid", 32'(con_valid), 32'd0);
        do_reset();
        repeat (3) tick();
        wr(32'h1000, 32'h1);
        check_eq("mr_pass", 32'(pass), 32'd1);
        check_eq("mr_cycle", cycle_count, 32'd4);

`ifdef TEST_MONITOR_CONSOLE_EN
        // Overflow: 9 pushes into a depth-8 FIFO, then ordered drain.
        do_reset();
        check_eq("ov_rst", 32'(con_overflow), 32'd0);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(8'h41 + 8'(i));
            wr(32'h1004, 32'h41 + 32'(i));
        end
        check_eq("ov_flag", 32'(con_overflow), 32'd1);
        check_eq("ov_valid", 32'(con_valid), 32'd1);
        drain(20);
        check_eq("ov_sticky", 32'(con_overflow), 32'd1);

        // Push into a full FIFO together with a pop.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h61 + 8'(i));
            wr(32'h1004, 32'h61 + 32'(i));
        end
        check_eq("pp_no_ov_pre", 32'(con_overflow), 32'd0);
        con_ready = 1'b1;
        check_eq("pp_head", 32'(con_data), 32'(exp_q.pop_front()));
        exp_q.push_back(8'h7A);
        wr(32'h1004, 32'h7A);
        con_ready = 1'b0;
        check_eq("pp_no_ov", 32'(con_overflow), 32'd0);
        wr(32'h1004, 32'h79);
        check_eq("pp_still_full", 32'(con_overflow), 32'd1);
        drain(20);
`else
        // Console disabled: outputs tied low regardless of writes.
        do_reset();
        con_ready = 1'b1;
        wr(32'h1004, 32'h41);
        wr(32'h1004, 32'h42);
        check_eq("nc_valid", 32'(con_valid), 32'd0);
        check_eq("nc_data", 32'(con_data), 32'd0);
        check_eq("nc_overflow", 32'(con_overflow), 32'd0);
        check_eq("nc_done", 32'(done), 32'd0);
        con_ready = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
